// File: rtl/rc4_decrypt.sv
// RC4 keystream pass: walks the shuffled S memory, swaps entries in place and
// writes ROM[k] ^ keystream into the decrypted-message RAM, one byte per 12 cycles.
module rc4_decrypt #(
    parameter int MSG_LEN = 32,
    parameter int MSG_AW  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        s_q,
    output logic [7:0]        s_address,
    output logic [7:0]        s_data,
    output logic              s_wren,
    input  logic [7:0]        rom_q,
    output logic [MSG_AW-1:0] rom_address,
    output logic [MSG_AW-1:0] ram_address,
    output logic [7:0]        ram_data,
    output logic              ram_wren,
    output logic              finish
);

    localparam logic [MSG_AW-1:0] K_LAST = MSG_AW'(MSG_LEN - 1);

    typedef enum logic [3:0] {
        IDLE,
        INC_I,
        WAIT_SI,
        READ_SI,
        WAIT_SJ,
        READ_SJ,
        WRITE_SI,
        WRITE_SJ,
        ADDR_F,
        WAIT_F,
        READ_F,
        WRITE_RAM,
        NEXT,
        DONE
    } state_t;

    state_t state, state_next;

    logic [7:0]        i, j, si, sj, f, enc;
    logic [MSG_AW-1:0] k;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath registers; j and the f address wrap naturally in 8 bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i   <= 8'd0;
            j   <= 8'd0;
            k   <= '0;
            si  <= 8'd0;
            sj  <= 8'd0;
            f   <= 8'd0;
            enc <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        i <= 8'd1;
                        j <= 8'd0;
                        k <= '0;
                    end
                end
                READ_SI: begin
                    si <= s_q;
                    j  <= j + s_q;
                end
                READ_SJ: begin
                    sj <= s_q;
                end
                READ_F: begin
                    f   <= s_q;
                    enc <= rom_q;
                end
                NEXT: begin
                    if (k != K_LAST) begin
                        k <= k + MSG_AW'(1);
                        i <= i + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next  = state;
        s_address   = 8'd0;
        s_data      = 8'd0;
        s_wren      = 1'b0;
        ram_wren    = 1'b0;
        finish      = 1'b0;
        rom_address = k;
        ram_address = k;
        ram_data    = f ^ enc;

        case (state)
            IDLE: begin
                if (start) state_next = INC_I;
            end
            INC_I: begin
                s_address  = i;
                state_next = WAIT_SI;
            end
            WAIT_SI: begin
                s_address  = i;
                state_next = READ_SI;
            end
            READ_SI: begin
                s_address  = i;
                state_next = WAIT_SJ;
            end
            WAIT_SJ: begin
                s_address  = j;
                state_next = READ_SJ;
            end
            READ_SJ: begin
                s_address  = j;
                state_next = WRITE_SI;
            end
            // When i == j both writes store the same value, leaving S unchanged.
            WRITE_SI: begin
                s_address  = i;
                s_data     = sj;
                s_wren     = 1'b1;
                state_next = WRITE_SJ;
            end
            WRITE_SJ: begin
                s_address  = j;
                s_data     = si;
                s_wren     = 1'b1;
                state_next = ADDR_F;
            end
            ADDR_F: begin
                s_address  = si + sj;
                state_next = WAIT_F;
            end
            WAIT_F: begin
                s_address  = si + sj;
                state_next = READ_F;
            end
            READ_F: begin
                s_address  = si + sj;
                state_next = WRITE_RAM;
            end
            WRITE_RAM: begin
                ram_wren   = 1'b1;
                state_next = NEXT;
            end
            NEXT: begin
                state_next = (k == K_LAST) ? DONE : INC_I;
            end
            DONE: begin
                finish = 1'b1;
                if (!start) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
